// File: rtl/sdram_responder.sv
// sdram_responder: synthesizable single-data-rate SDRAM device model.
// Decodes commands, tracks banks and mode, stores bytes, returns CL-delayed reads.
module sdram_responder #(
    parameter int ROW_WIDTH     = 13,
    parameter int COL_WIDTH     = 10,
    parameter int BANK_WIDTH    = 2,
    parameter int SDRADDR_WIDTH = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH,
    parameter int MEM_AW        = 12,
    parameter int TRCD          = 2,
    parameter int TRP           = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clock_enable,
    input  logic                     cs_n,
    input  logic                     ras_n,
    input  logic                     cas_n,
    input  logic                     we_n,
    input  logic [BANK_WIDTH-1:0]    bank_addr,
    input  logic [SDRADDR_WIDTH-1:0] addr,
    input  logic                     data_mask,
    input  logic [7:0]               data_in,
    output logic [7:0]               data_out,
    output logic                     data_oe,
    output logic                     mode_valid,
    output logic [1:0]               cas_latency,
    output logic [15:0]              ref_count,
    output logic                     err,
    output logic [2:0]               err_code
);

    localparam int NB = 1 << BANK_WIDTH;
    localparam int TW = 4;
    localparam logic [TW-1:0] TRCD_LD = TW'(TRCD - 1);
    localparam logic [TW-1:0] TRP_LD  = TW'(TRP - 1);

    typedef struct packed {
        logic              v;
        logic              drv;
        logic [MEM_AW-1:0] idx;
    } beat_t;

    logic [7:0]           mem [0:(1<<MEM_AW)-1];
    logic [NB-1:0]        open_q;
    logic [ROW_WIDTH-1:0] row_q  [NB];
    logic [TW-1:0]        trcd_q [NB];
    logic [TW-1:0]        trp_q  [NB];
    beat_t                s1_q, s2_q, s1_d, s2_d;

    logic              is_act, is_rd, is_wr, is_pre, is_ref, is_mrs;
    logic              bank_open, mrs_ok, do_act, do_rw, auto_pre;
    logic [2:0]        err_new;
    logic [MEM_AW-1:0] idx;

    // Command decode; CKE low, deselect and unused codes reduce to no action.
    always_comb begin
        is_act = 1'b0;
        is_rd  = 1'b0;
        is_wr  = 1'b0;
        is_pre = 1'b0;
        is_ref = 1'b0;
        is_mrs = 1'b0;
        if (clock_enable && !cs_n) begin
            case ({ras_n, cas_n, we_n})
                3'b011:  is_act = 1'b1;
                3'b101:  is_rd  = 1'b1;
                3'b100:  is_wr  = 1'b1;
                3'b010:  is_pre = 1'b1;
                3'b001:  is_ref = 1'b1;
                3'b000:  is_mrs = 1'b1;
                default: ;
            endcase
        end
    end

    assign bank_open = open_q[bank_addr];
    assign mrs_ok    = (addr[6:5] == 2'b01) && (addr[2:0] == 3'b000);
    assign do_act    = is_act && mode_valid;
    assign do_rw     = (is_rd || is_wr) && mode_valid && bank_open;
    assign auto_pre  = do_rw && addr[10];
    assign idx       = MEM_AW'({bank_addr, row_q[bank_addr], addr[COL_WIDTH-1:0]});

    // Protocol checks; the lowest applicable code wins for this command.
    always_comb begin
        err_new = 3'd0;
        if (is_act) begin
            if (!mode_valid)                 err_new = 3'd1;
            else if (bank_open)              err_new = 3'd3;
            else if (trp_q[bank_addr] != '0) err_new = 3'd5;
        end else if (is_rd || is_wr) begin
            if (!mode_valid)                  err_new = 3'd1;
            else if (!bank_open)              err_new = 3'd2;
            else if (trcd_q[bank_addr] != '0) err_new = 3'd4;
        end else if (is_mrs && !mrs_ok) begin
            err_new = 3'd6;
        end else if (is_ref && (open_q != '0)) begin
            err_new = 3'd7;
        end
    end

    // Read pipeline advance; CL3 reads enter one slot further back than CL2.
    always_comb begin
        s1_d = s2_q;
        s2_d = '0;
        if (do_rw && is_rd) begin
            if (cas_latency == 2'd3) begin
                s2_d.v   = 1'b1;
                s2_d.drv = !data_mask;
                s2_d.idx = idx;
            end else begin
                s1_d.v   = 1'b1;
                s1_d.drv = !data_mask;
                s1_d.idx = idx;
            end
        end
    end

    // Per-bank open row and tRCD/tRP countdowns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q <= '0;
            for (int i = 0; i < NB; i++) begin
                row_q[i]  <= '0;
                trcd_q[i] <= '0;
                trp_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (trcd_q[i] != '0) trcd_q[i] <= trcd_q[i] - TW'(1);
                if (trp_q[i] != '0)  trp_q[i]  <= trp_q[i] - TW'(1);
                if (bank_addr == BANK_WIDTH'(i)) begin
                    if (do_act) begin
                        open_q[i] <= 1'b1;
                        row_q[i]  <= addr[ROW_WIDTH-1:0];
                        trcd_q[i] <= TRCD_LD;
                    end
                    if (auto_pre) begin
                        open_q[i] <= 1'b0;
                        trp_q[i]  <= TRP_LD;
                    end
                end
                if (is_pre && (addr[10] || bank_addr == BANK_WIDTH'(i))) begin
                    open_q[i] <= 1'b0;
                    trp_q[i]  <= TRP_LD;
                end
            end
        end
    end

    // Mode register, refresh counter and sticky first error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_valid  <= 1'b0;
            cas_latency <= 2'd2;
            ref_count   <= '0;
            err         <= 1'b0;
            err_code    <= '0;
        end else begin
            if (is_mrs && mrs_ok) begin
                mode_valid  <= 1'b1;
                cas_latency <= addr[5:4];
            end
            if (is_ref && ref_count != 16'hFFFF)
                ref_count <= ref_count + 16'd1;
            if (!err && err_new != 3'd0) begin
                err      <= 1'b1;
                err_code <= err_new;
            end
        end
    end

    // Read beat slots and the DQ output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            data_out <= '0;
            data_oe  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            data_oe <= s1_q.v && s1_q.drv;
            if (s1_q.v && s1_q.drv)
                data_out <= mem[s1_q.idx];
        end
    end

    // Backing store; contents survive reset.
    always_ff @(posedge clk) begin
        if (do_rw && is_wr && !data_mask)
            mem[idx] <= data_in;
    end

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: directed and randomized checks of sdram_responder
// against an edge-numbered behavioural model of the device.
module tb_sdram_responder;

    localparam int ROW_WIDTH = 13;
    localparam int COL_WIDTH = 10;
    localparam int MEM_AW    = 12;
    localparam int TRCD      = 2;
    localparam int TRP       = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clock_enable, cs_n, ras_n, cas_n, we_n;
    logic [1:0]  bank_addr;
    logic [12:0] addr;
    logic        data_mask;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe, mode_valid;
    logic [1:0]  cas_latency;
    logic [15:0] ref_count;
    logic        err;
    logic [2:0]  err_code;

    int checks   = 0;
    int failures = 0;

    sdram_responder dut (
        .clk(clk), .rst_n(rst_n), .clock_enable(clock_enable),
        .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .bank_addr(bank_addr), .addr(addr), .data_mask(data_mask),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .mode_valid(mode_valid), .cas_latency(cas_latency),
        .ref_count(ref_count), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int due; int idx; bit drv; } beat_t;
    beat_t      bq[$];
    logic [7:0] mm [4096];
    bit         kn [4096];
    bit         m_open [4];
    int         m_row [4];
    int         m_act [4];
    int         m_pre [4];
    int         en;
    bit         started = 0;
    bit         e_oe, e_dchk, e_mv, e_err;
    int         e_dout, e_cl, e_ref, e_code;

    task automatic seterr(input int c);
        if (!e_err) begin
            e_err  = 1;
            e_code = c;
        end
    endtask

    task automatic model_cmd();
        int b, col, ix;
        bit any;
        beat_t nb;
        b   = int'(bank_addr);
        col = int'(addr[9:0]);
        if (!clock_enable || cs_n) return;
        case ({ras_n, cas_n, we_n})
            3'b011: begin
                if (!e_mv) seterr(1);
                else begin
                    if (m_open[b]) seterr(3);
                    else if (en - m_pre[b] < TRP) seterr(5);
                    m_open[b] = 1;
                    m_row[b]  = int'(addr);
                    m_act[b]  = en;
                end
            end
            3'b101, 3'b100: begin
                if (!e_mv) seterr(1);
                else if (!m_open[b]) seterr(2);
                else begin
                    if (en - m_act[b] < TRCD) seterr(4);
                    ix = (b * (1 << (ROW_WIDTH + COL_WIDTH)) + m_row[b] * (1 << COL_WIDTH) + col)
                         % (1 << MEM_AW);
                    if (we_n) begin
                        nb.due = en + e_cl - 1;
                        nb.idx = ix;
                        nb.drv = !data_mask;
                        bq.push_back(nb);
                    end else if (!data_mask) begin
                        mm[ix] = data_in;
                        kn[ix] = 1;
                    end
                    if (addr[10]) begin
                        m_open[b] = 0;
                        m_pre[b]  = en;
                    end
                end
            end
            3'b010: begin
                for (int i = 0; i < 4; i++)
                    if (addr[10] || i == b) begin
                        m_open[i] = 0;
                        m_pre[i]  = en;
                    end
            end
            3'b001: begin
                any = 0;
                for (int i = 0; i < 4; i++) if (m_open[i]) any = 1;
                if (any) seterr(7);
                if (e_ref < 65535) e_ref++;
            end
            3'b000: begin
                if ((addr[6:4] == 3'd2 || addr[6:4] == 3'd3) && addr[2:0] == 3'd0) begin
                    e_mv = 1;
                    e_cl = int'(addr[5:4]);
                end else seterr(6);
            end
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started = 1;
            bq.delete();
            e_oe = 0; e_dout = 0; e_dchk = 1;
            e_mv = 0; e_cl = 2; e_ref = 0; e_err = 0; e_code = 0;
            en = 0;
            for (int i = 0; i < 4; i++) begin
                m_open[i] = 0;
                m_act[i]  = -100;
                m_pre[i]  = -100;
            end
        end else begin
            en++;
            e_oe = 0;
            e_dchk = 0;
            for (int i = 0; i < bq.size(); i++) begin
                if (bq[i].due == en) begin
                    if (bq[i].drv) begin
                        e_oe = 1;
                        if (kn[bq[i].idx]) begin
                            e_dchk = 1;
                            e_dout = int'(mm[bq[i].idx]);
                        end
                    end
                    bq.delete(i);
                    break;
                end
            end
            model_cmd();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("data_oe", int'(data_oe), int'(e_oe));
            if (e_dchk) check("data_out", int'(data_out), e_dout);
            check("mode_valid", int'(mode_valid), int'(e_mv));
            check("cas_latency", int'(cas_latency), e_cl);
            check("ref_count", int'(ref_count), e_ref);
            check("err", int'(err), int'(e_err));
            check("err_code", int'(err_code), e_code);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [3:0] c, input int ba, input int a,
                         input bit dm, input int d, input bit ce);
        {cs_n, ras_n, cas_n, we_n} = c;
        clock_enable = ce;
        bank_addr    = 2'(ba);
        addr         = 13'(a);
        data_mask    = dm;
        data_in      = 8'(d);
        @(posedge clk);
        #2;
    endtask

    task automatic nop();
        drive(4'b0111, 0, 0, 0, 0, 1);
    endtask
    task automatic act(input int ba, input int row);
        drive(4'b0011, ba, row, 0, 0, 1);
    endtask
    task automatic rd(input int ba, input int col, input bit ap, input bit dm);
        drive(4'b0101, ba, col | (ap ? 1024 : 0), dm, 0, 1);
    endtask
    task automatic wr(input int ba, input int col, input bit ap, input bit dm, input int d);
        drive(4'b0100, ba, col | (ap ? 1024 : 0), dm, d, 1);
    endtask
    task automatic pre(input int ba, input bit all);
        drive(4'b0010, ba, all ? 1024 : 0, 0, 0, 1);
    endtask
    task automatic refc();
        drive(4'b0001, 0, 0, 0, 0, 1);
    endtask
    task automatic mrs(input int a);
        drive(4'b0000, 0, a, 0, 0, 1);
    endtask

    task automatic set_nop();
        {cs_n, ras_n, cas_n, we_n} = 4'b0111;
        clock_enable = 1'b1;
    endtask

    task automatic reset_pulse();
        set_nop();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_oe"}, int'(data_oe), 0);
        check({tag, "_dout"}, int'(data_out), 0);
        check({tag, "_mv"}, int'(mode_valid), 0);
        check({tag, "_cl"}, int'(cas_latency), 2);
        check({tag, "_ref"}, int'(ref_count), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_code"}, int'(err_code), 0);
    endtask

    task automatic rand_cmd();
        int r, b, a, ib;
        int ob[$];
        int fb[$];
        int mt[6];
        mt = '{'h020, 'h030, 'h220, 'h230, 'h040, 'h031};
        r  = $urandom_range(0, 99);
        for (int i = 0; i < 4; i++) begin
            if (m_open[i]) ob.push_back(i);
            else fb.push_back(i);
        end
        b = $urandom_range(0, 3);
        if (ob.size() > 0 && $urandom_range(0, 9) != 0)
            b = ob[$urandom_range(0, ob.size() - 1)];
        ib = $urandom_range(0, 3);
        if (fb.size() > 0 && $urandom_range(0, 9) != 0)
            ib = fb[$urandom_range(0, fb.size() - 1)];
        a = $urandom_range(0, 15) | (($urandom_range(0, 3) == 0) ? 1024 : 0)
            | ($urandom_range(0, 3) << 11);
        if (r < 8)       nop();
        else if (r < 11) drive({1'b1, 3'($urandom)}, b, a, 0, 0, 1);
        else if (r < 14) drive(4'($urandom), b, a, 0, 0, 0);
        else if (r < 28) act(ib, $urandom_range(0, 8191));
        else if (r < 56) drive(4'b0101, b, a, $urandom_range(0, 6) == 0, 0, 1);
        else if (r < 82) drive(4'b0100, b, a, $urandom_range(0, 6) == 0,
                               $urandom_range(0, 255), 1);
        else if (r < 90) pre($urandom_range(0, 3), $urandom_range(0, 2) == 0);
        else if (r < 94) refc();
        else if (r < 98) mrs(mt[$urandom_range(0, 3)]);
        else if (r < 99) mrs(mt[$urandom_range(4, 5)]);
        else             drive(4'b0110, b, a, 0, 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        set_nop();
        bank_addr = '0; addr = '0; data_mask = 1'b0; data_in = '0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst");

        // init: PRE-all, two refreshes, CL3 mode
        pre(0, 1);
        refc();
        refc();
        mrs('h230);
        @(negedge clk);
        check("init_mv", int'(mode_valid), 1);
        check("init_cl", int'(cas_latency), 3);
        check("init_ref", int'(ref_count), 2);
        check("init_err", int'(err), 0);
        check("model_ref", e_ref, 2);
        check("model_cl", e_cl, 3);

        // CL3 write/auto-precharge/read round trip
        act(1, 'h55);
        nop(); nop();
        wr(1, 'h12, 1, 0, 'hA5);
        nop(); nop();
        act(1, 'h55);
        nop(); nop();
        rd(1, 'h12, 1, 0);
        @(negedge clk);
        check("cl3_k0_oe", int'(data_oe), 0);
        nop();
        @(negedge clk);
        check("cl3_k1_oe", int'(data_oe), 0);
        nop();
        @(negedge clk);
        check("cl3_k2_oe", int'(data_oe), 1);
        check("cl3_k2_dout", int'(data_out), 'hA5);
        nop();
        @(negedge clk);
        check("cl3_k3_oe", int'(data_oe), 0);
        refc();
        @(negedge clk);
        check("idle_ref_err", int'(err), 0);

        // CL2 back-to-back reads
        mrs('h220);
        @(negedge clk);
        check("cl2_cl", int'(cas_latency), 2);
        act(2, 0);
        nop(); nop();
        for (int i = 0; i < 4; i++) wr(2, 'h20 + i, 0, 0, i + 1);
        for (int i = 0; i < 4; i++) begin
            rd(2, 'h20 + i, 0, 0);
            @(negedge clk);
            if (i == 0) check("b2b_first_oe", int'(data_oe), 0);
            else begin
                check("b2b_oe", int'(data_oe), 1);
                check("b2b_dout", int'(data_out), i);
            end
        end
        nop();
        @(negedge clk);
        check("b2b_last_oe", int'(data_oe), 1);
        check("b2b_last_dout", int'(data_out), 4);
        nop();
        @(negedge clk);
        check("b2b_end_oe", int'(data_oe), 0);

        // masked write and masked read
        wr(2, 'h30, 0, 0, 'h3C);
        wr(2, 'h30, 0, 1, 'h77);
        rd(2, 'h30, 0, 0);
        nop();
        @(negedge clk);
        check("mask_wr_oe", int'(data_oe), 1);
        check("mask_wr_dout", int'(data_out), 'h3C);
        rd(2, 'h30, 0, 1);
        for (int i = 0; i < 3; i++) begin
            nop();
            @(negedge clk);
            check("mask_rd_oe", int'(data_oe), 0);
        end
        check("pre_err_clean", int'(err), 0);

        // read to idle bank, then a tRCD violation keeps the first code
        rd(3, 0, 0, 0);
        @(negedge clk);
        check("idle_err", int'(err), 1);
        check("idle_code", int'(err_code), 2);
        nop();
        @(negedge clk);
        check("idle_nobeat", int'(data_oe), 0);
        nop();
        act(3, 5);
        rd(3, 1, 0, 0);
        @(negedge clk);
        check("trcd_code", int'(err_code), 2);
        nop(); nop(); nop();

        // reset mid-read cancels the beat; memory survives
        reset_pulse();
        mrs('h230);
        act(1, 'h55);
        nop(); nop();
        rd(1, 'h12, 0, 0);
        set_nop();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrd");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        nop();
        @(negedge clk);
        check("midrd_after_oe", int'(data_oe), 0);
        mrs('h230);
        act(1, 'h55);
        nop(); nop();
        rd(1, 'h12, 1, 0);
        nop(); nop();
        @(negedge clk);
        check("persist_oe", int'(data_oe), 1);
        check("persist_dout", int'(data_out), 'hA5);
        nop();

        // randomized segments, each from a fresh reset
        for (int s = 0; s < 8; s++) begin
            reset_pulse();
            pre(0, 1);
            mrs((s % 2 == 0) ? 'h230 : 'h220);
            repeat (250) rand_cmd();
            repeat (4) nop();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
